// File: rtl/addsub_issue_ctrl.sv
// addsub_issue_ctrl: request FIFO, issue control and result slot
// wrapped around the combinational farc_addsub core, plus overflow stats.
module addsub_issue_ctrl #(
    parameter int ADDER_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid_in,
    output logic                   req_ready_out,
    input  logic [ADDER_WIDTH-1:0] req_a_in,
    input  logic [ADDER_WIDTH-1:0] req_b_in,
    input  logic                   req_sm2c_in,
    input  logic                   req_sub_in,
    output logic [ADDER_WIDTH-1:0] core_a_out,
    output logic [ADDER_WIDTH-1:0] core_b_out,
    output logic                   core_sm2c_out,
    output logic                   core_sub_out,
    input  logic [ADDER_WIDTH-1:0] core_sum_in,
    input  logic                   core_carry_in,
    input  logic                   core_ovf_in,
    output logic                   res_valid_out,
    input  logic                   res_ready_in,
    output logic [ADDER_WIDTH-1:0] res_sum_out,
    output logic                   res_carry_out,
    output logic                   res_ovf_out,
    output logic [7:0]             res_tag_out,
    output logic                   ovf_sticky_out,
    output logic [CNT_WIDTH-1:0]   ovf_count_out,
    input  logic                   clr_stat_in
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDER_WIDTH-1:0] a;
        logic [ADDER_WIDTH-1:0] b;
        logic                   sm2c;
        logic                   sub;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [7:0]    tag;
    logic          full;
    logic          empty;
    logic          push;
    logic          issue;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Ready is forced low while reset is held so nothing is accepted then.
    assign req_ready_out = rst_n & ~full;
    assign push          = req_valid_in & req_ready_out;
    assign issue         = ~empty & (~res_valid_out | res_ready_in);

    assign head          = mem[rd_ptr];
    assign core_a_out    = empty ? '0 : head.a;
    assign core_b_out    = empty ? '0 : head.b;
    assign core_sm2c_out = empty ? 1'b0 : head.sm2c;
    assign core_sub_out  = empty ? 1'b0 : head.sub;

    // FIFO storage; contents are only visible through the head when non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: req_a_in, b: req_b_in,
                             sm2c: req_sm2c_in, sub: req_sub_in};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Result slot: capture the core output on issue, drop valid on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_out <= 1'b0;
            res_sum_out   <= '0;
            res_carry_out <= 1'b0;
            res_ovf_out   <= 1'b0;
            res_tag_out   <= '0;
            tag           <= '0;
        end else if (issue) begin
            res_valid_out <= 1'b1;
            res_sum_out   <= core_sum_in;
            res_carry_out <= core_carry_in;
            res_ovf_out   <= core_ovf_in;
            res_tag_out   <= tag;
            tag           <= tag + 8'd1;
        end else if (res_valid_out && res_ready_in) begin
            res_valid_out <= 1'b0;
        end
    end

    // Overflow statistics; a new overflow takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_out <= 1'b0;
            ovf_count_out  <= '0;
        end else if (issue && core_ovf_in) begin
            ovf_sticky_out <= 1'b1;
            if (clr_stat_in) begin
                ovf_count_out <= CNT_WIDTH'(1);
            end else if (ovf_count_out != '1) begin
                ovf_count_out <= ovf_count_out + 1'b1;
            end
        end else if (clr_stat_in) begin
            ovf_sticky_out <= 1'b0;
            ovf_count_out  <= '0;
        end
    end

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
// tb_addsub_issue_ctrl: directed and random stimulus against a
// queue-based transaction model with a behavioural add/sub core.
module tb_addsub_issue_ctrl;

    localparam int AW = 8;
    localparam int DEPTH = 4;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid_in = 1'b0;
    logic          req_ready_out;
    logic [AW-1:0] req_a_in = '0;
    logic [AW-1:0] req_b_in = '0;
    logic          req_sm2c_in = 1'b0;
    logic          req_sub_in = 1'b0;
    logic [AW-1:0] core_a_out;
    logic [AW-1:0] core_b_out;
    logic          core_sm2c_out;
    logic          core_sub_out;
    logic [AW-1:0] core_sum_in;
    logic          core_carry_in;
    logic          core_ovf_in;
    logic          res_valid_out;
    logic          res_ready_in = 1'b0;
    logic [AW-1:0] res_sum_out;
    logic          res_carry_out;
    logic          res_ovf_out;
    logic [7:0]    res_tag_out;
    logic          ovf_sticky_out;
    logic [CW-1:0] ovf_count_out;
    logic          clr_stat_in = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural core: returns {carry, ovf, sum}.
    function automatic logic [9:0] core_f(logic [7:0] a, logic [7:0] b,
                                          logic sm, logic sub);
        logic [8:0]  t;
        logic [7:0]  b2;
        logic [31:0] m;
        int va, vb, r;
        if (!sm) begin
            b2 = sub ? ~b : b;
            t = {1'b0, a} + {1'b0, b2} + 9'(sub);
            return {t[8], (a[7] == b2[7]) && (t[7] != a[7]), t[7:0]};
        end
        va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
        vb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
        r = sub ? va - vb : va + vb;
        m = (r < 0) ? -r : r;
        return {m[7], m > 127, (r < 0), m[6:0]};
    endfunction

    logic [9:0] core_res;
    assign core_res = core_f(core_a_out, core_b_out, core_sm2c_out, core_sub_out);
    assign core_sum_in = core_res[7:0];
    assign core_ovf_in = core_res[8];
    assign core_carry_in = core_res[9];

    addsub_issue_ctrl #(.ADDER_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_a_in(req_a_in), .req_b_in(req_b_in),
        .req_sm2c_in(req_sm2c_in), .req_sub_in(req_sub_in),
        .core_a_out(core_a_out), .core_b_out(core_b_out),
        .core_sm2c_out(core_sm2c_out), .core_sub_out(core_sub_out),
        .core_sum_in(core_sum_in), .core_carry_in(core_carry_in),
        .core_ovf_in(core_ovf_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
        .res_sum_out(res_sum_out), .res_carry_out(res_carry_out),
        .res_ovf_out(res_ovf_out), .res_tag_out(res_tag_out),
        .ovf_sticky_out(ovf_sticky_out), .ovf_count_out(ovf_count_out),
        .clr_stat_in(clr_stat_in)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic       sub;
    } req_t;

    // Transaction model: pending requests plus the expected result slot.
    req_t       fifo_q[$];
    logic       m_valid;
    logic [7:0] m_sum;
    logic       m_carry;
    logic       m_ovf;
    logic [7:0] m_tag;
    logic [7:0] m_next_tag;
    logic       m_sticky;
    int         m_cnt;
    bit         last_push;

    task automatic chk(string nm, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic model_reset();
        fifo_q.delete();
        m_valid = 1'b0;
        m_sum = '0;
        m_carry = 1'b0;
        m_ovf = 1'b0;
        m_tag = '0;
        m_next_tag = '0;
        m_sticky = 1'b0;
        m_cnt = 0;
    endtask

    task automatic chk_outputs();
        chk("res_valid", res_valid_out, m_valid);
        chk("res_sum", res_sum_out, m_sum);
        chk("res_carry", res_carry_out, m_carry);
        chk("res_ovf", res_ovf_out, m_ovf);
        chk("res_tag", res_tag_out, m_tag);
        chk("sticky", ovf_sticky_out, m_sticky);
        chk("count", ovf_count_out, m_cnt);
    endtask

    // One clock: check pre-edge signals, advance model, check post-edge.
    task automatic cycle();
        bit push, issue;
        req_t r;
        logic [9:0] c;
        chk("req_ready", req_ready_out, fifo_q.size() < DEPTH);
        if (fifo_q.size() > 0) begin
            r = fifo_q[0];
            chk("core_ops", {core_a_out, core_b_out, core_sm2c_out, core_sub_out}, r);
        end else begin
            chk("core_idle", {core_a_out, core_b_out, core_sm2c_out, core_sub_out}, 0);
        end
        push = req_valid_in && (fifo_q.size() < DEPTH);
        issue = (fifo_q.size() > 0) && (!m_valid || res_ready_in);
        if (clr_stat_in) begin
            m_sticky = 1'b0;
            m_cnt = 0;
        end
        if (issue) begin
            r = fifo_q.pop_front();
            c = core_f(r.a, r.b, r.sm, r.sub);
            m_sum = c[7:0];
            m_ovf = c[8];
            m_carry = c[9];
            m_tag = m_next_tag;
            m_next_tag = m_next_tag + 8'd1;
            m_valid = 1'b1;
            if (m_ovf) begin
                m_sticky = 1'b1;
                if (m_cnt < CMAX) m_cnt++;
            end
        end else if (m_valid && res_ready_in) begin
            m_valid = 1'b0;
        end
        if (push) fifo_q.push_back('{req_a_in, req_b_in, req_sm2c_in, req_sub_in});
        last_push = push;
        @(posedge clk);
        #1;
        chk_outputs();
    endtask

    task automatic push_op(logic [7:0] a, logic [7:0] b, logic sm, logic sub);
        req_valid_in = 1'b1;
        req_a_in = a;
        req_b_in = b;
        req_sm2c_in = sm;
        req_sub_in = sub;
        cycle();
        req_valid_in = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_ready", req_ready_out, 0);
        chk_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        res_ready_in = 1'b1;

        push_op(8'h12, 8'h05, 1'b0, 1'b0);
        idle(1);
        chk("add2c_sum", res_sum_out, 8'h17);
        chk("add2c_ovf", res_ovf_out, 0);
        chk("add2c_tag", res_tag_out, 0);
        chk("add2c_vld", res_valid_out, 1);

        push_op(8'h05, 8'h83, 1'b1, 1'b0);
        idle(1);
        chk("smadd_sum", res_sum_out, 8'h02);
        chk("smadd_ovf", res_ovf_out, 0);
        push_op(8'h03, 8'h05, 1'b1, 1'b1);
        idle(1);
        chk("smsub_sum", res_sum_out, 8'h82);

        push_op(8'h7F, 8'h01, 1'b0, 1'b0);
        idle(1);
        chk("ovf_sum", res_sum_out, 8'h80);
        chk("ovf_flag", res_ovf_out, 1);
        chk("ovf_sticky", ovf_sticky_out, 1);
        chk("ovf_count", ovf_count_out, 1);
        clr_stat_in = 1'b1;
        idle(1);
        clr_stat_in = 1'b0;
        chk("clr_sticky", ovf_sticky_out, 0);
        chk("clr_count", ovf_count_out, 0);

        // Backpressure: slot held, FIFO fills, then drains in order.
        res_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) push_op(8'(i + 1), 8'h10, 1'b0, 1'b0);
        chk("bp_full", req_ready_out, 0);
        chk("bp_slot_sum", res_sum_out, 8'h11);
        req_valid_in = 1'b1;
        req_a_in = 8'h60;
        cycle();
        cycle();
        chk("bp_stall", last_push, 0);
        res_ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_push) break;
        end
        chk("bp_accept", last_push, 1);
        req_valid_in = 1'b0;
        idle(8);

        // Counter saturation.
        for (int i = 0; i < 5; i++) push_op(8'h7F, 8'h01, 1'b0, 1'b0);
        idle(2);
        chk("sat_count", ovf_count_out, 2'b11);

        // Clear coinciding with an overflowing issue.
        clr_stat_in = 1'b1;
        idle(1);
        clr_stat_in = 1'b0;
        push_op(8'h80, 8'hFF, 1'b0, 1'b0);
        push_op(8'h7F, 8'h7F, 1'b0, 1'b0);
        idle(1);
        chk("pre_clr_count", ovf_count_out, 2);
        push_op(8'h7F, 8'h01, 1'b0, 1'b0);
        clr_stat_in = 1'b1;
        idle(1);
        clr_stat_in = 1'b0;
        chk("clr_win_count", ovf_count_out, 1);
        chk("clr_win_sticky", ovf_sticky_out, 1);

        // Asynchronous reset with a held result and queued requests.
        res_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) push_op(8'h70, 8'(i + 8'h20), 1'b0, 1'b0);
        chk("pre_rst_vld", res_valid_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_ready", req_ready_out, 0);
        chk_outputs();
        #1;
        rst_n = 1'b1;
        res_ready_in = 1'b1;
        @(posedge clk);
        #1;
        push_op(8'h01, 8'h02, 1'b0, 1'b0);
        idle(1);
        chk("post_rst_tag", res_tag_out, 0);
        chk("post_rst_sum", res_sum_out, 8'h03);

        // Tag wrap: 256 more issues after tag 0.
        req_valid_in = 1'b1;
        for (int i = 0; i < 256; i++) begin
            req_a_in = 8'($urandom);
            req_b_in = 8'($urandom);
            req_sm2c_in = 1'($urandom);
            req_sub_in = 1'($urandom);
            cycle();
        end
        req_valid_in = 1'b0;
        idle(1);
        chk("tag_wrap", res_tag_out, 0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            req_valid_in = ($urandom_range(0, 3) != 0);
            req_a_in = 8'($urandom);
            req_b_in = 8'($urandom);
            req_sm2c_in = 1'($urandom);
            req_sub_in = 1'($urandom);
            res_ready_in = ($urandom_range(0, 2) != 0);
            clr_stat_in = ($urandom_range(0, 15) == 0);
            cycle();
        end
        req_valid_in = 1'b0;
        clr_stat_in = 1'b0;
        res_ready_in = 1'b1;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
